audio_adc_rx: RTL and testbench
===============================

AUDIO_ADC_RX -- requirements
Module: audio_adc_rx

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning sample width in bits (I2S slot bits captured per channel).
REQ-002 SHALL have parameter PEAK_DECAY_W, default 22, meaning peak-meter decay period of 2^PEAK_DECAY_W clk cycles.
REQ-003 SHALL have one clock and an asynchronous active-low reset, named as the codebase does:
- clk  in  1  system clock (28 MHz class); the only clock.
- rst_n  in  1  asynchronous active-low reset.
REQ-004 SHALL have the following data ports:
- aud_bclk  in  1  codec bit clock (FPGA-generated, shared with the DAC path).
- aud_adclrck  in  1  ADC LR clock; 0 = left, 1 = right.
- aud_adcdat  in  1  ADC serial data, I2S format, MSB first.
- ldata  out  DATA_W  left sample, two's complement.
- rdata  out  DATA_W  right sample, two's complement.
- out_valid  out  1  sample pair available.
- out_ready  in  1  consumer accepts pair.
- overrun  out  1  sticky flag: pair lost.
- clr_overrun  in  1  clears overrun.
- peak_l  out  4  left level meter.
- peak_r  out  4  right level meter.

Function
REQ-005 SHALL pass aud_bclk, aud_adclrck and aud_adcdat through 2-FF synchronizers, then detect bclk rising edges on the synchronized signal (one extra register).
REQ-006 SHALL, on each detected bclk rise, sample the synchronized lrck and dat; all serial activity advances only on these events.
REQ-007 SHALL implement the states WAIT_SYNC, SKIP, SHIFT and HOLD.
- WAIT_SYNC: reset state; ignore data until the sampled lrck differs from the previous sample -> SKIP.
- SKIP: the I2S one-bit delay slot; discard the bit -> SHIFT, bitcnt=0.
- SHIFT: shift dat in MSB first, bitcnt++; at bitcnt==DATA_W latch the word into the channel register given by lrck -> HOLD.
- HOLD: ignore further bits until an lrck change -> SKIP.
REQ-008 SHALL, on an lrck change in any state other than WAIT_SYNC, immediately restart with the delay slot; a partial word (bitcnt<DATA_W) SHALL be discarded.
REQ-009 SHALL track a left-captured flag; when the right word completes with the flag set, SHALL present the pair on ldata/rdata and clear the flag. A right word without a preceding left word SHALL be dropped.
REQ-010 SHALL assert out_valid on the clk edge after the capture edge; pin-to-out_valid latency is 4 clk cycles after the final right-bit bclk rise reaches the pin.
REQ-011 SHALL hold out_valid, ldata and rdata stable until out_valid&&out_ready at a clk edge, then deassert out_valid (transfer).
REQ-012 SHALL, when a new pair completes while out_valid&&!out_ready, overwrite ldata/rdata, keep out_valid=1 and set overrun.
REQ-013 SHALL, when a new pair completes in the same cycle as a transfer, load the new pair, keep out_valid=1 and not set overrun.
REQ-014 SHALL clear overrun on clr_overrun; a simultaneous set SHALL win.

Reset
REQ-015 SHALL, while rst_n=0, force ldata=0, rdata=0, out_valid=0, overrun=0, peak_l=0, peak_r=0, state=WAIT_SYNC, bitcnt=0, left flag=0, synchronizers=0.
REQ-016 SHALL, when reset asserts mid-word, discard the word; after release, SHALL capture nothing before a fresh lrck transition.

Configuration
REQ-017 SHALL compile the peak meter in with macro AUDIO_ADC_RX_PEAK_EN.
- Defined: on each pair, level = bits [DATA_W-2 -: 4] of |sample| (saturate -32768 to 32767); peak = max(peak, level).
- Defined: a free-running PEAK_DECAY_W counter decrements each nonzero peak by 1 on wrap.
- Defined: an update and a decay in the same cycle apply the max after the decrement.
- Undefined: peak_l and peak_r are tied to 0, ports remain, no counter logic.

Structure
REQ-018 SHALL place the DATA_W default, the state enum (WAIT_SYNC, SKIP, SHIFT, HOLD) and the channel constants (CH_LEFT=0, CH_RIGHT=1) in the shared package audio_pkg.
REQ-019 SHALL use one sub-module sync_edge (2-FF synchronizer plus rising-edge pulse), instanced for bclk; lrck and dat use its synchronizer path only.

Verification
REQ-020 SHALL cover the following directed scenarios:
- I2S frame L=0x1234, R=0xABCD, out_ready=1 -> one out_valid pulse, ldata=0x1234, rdata=0xABCD, overrun=0.
- Three frames with out_ready=0 -> out_valid held high, data = third pair, overrun=1; clr_overrun -> overrun=0.
- Stream starting mid right channel -> first partial right word dropped, first pair emitted is the next complete L/R.
- lrck toggles after 9 left bits -> word discarded, no out_valid, next full frame captured correctly.
- rst_n pulsed low during the 8th left bit -> all outputs 0; no capture until the next lrck edge; subsequent frame correct.
- With AUDIO_ADC_RX_PEAK_EN: L=0x8000 -> peak_l=15; after 2^PEAK_DECAY_W silent cycles -> peak_l=14. Without the macro -> peak_l=0.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared audio definitions: default sample width, I2S receiver states and
// channel encodings used by the codec interface blocks.
package audio_pkg;

  localparam int unsigned AUDIO_DATA_W = 16;

  typedef enum logic [1:0] {
    WAIT_SYNC = 2'd0,
    SKIP      = 2'd1,
    SHIFT     = 2'd2,
    HOLD      = 2'd3
  } rx_state_e;

  localparam logic CH_LEFT  = 1'b0;
  localparam logic CH_RIGHT = 1'b1;

endpackage

// File: rtl/audio_adc_rx_sync_edge.sv
// sync_edge: 2-FF synchronizer for one edge-detected signal plus a bundle of
// level-only signals. rise pulses for one clk cycle after the synchronized
// edge_in goes high.
module sync_edge #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         edge_in,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         rise
);

  logic [W-1:0] din_meta;
  logic         edge_meta;
  logic         edge_sync;
  logic         edge_prev;

  // Two-stage synchronizer for all inputs, one extra stage on the edge signal.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      din_meta  <= '0;
      dout      <= '0;
      edge_meta <= 1'b0;
      edge_sync <= 1'b0;
      edge_prev <= 1'b0;
    end else begin
      din_meta  <= din;
      dout      <= din_meta;
      edge_meta <= edge_in;
      edge_sync <= edge_meta;
      edge_prev <= edge_sync;
    end
  end

  assign rise = edge_sync & ~edge_prev;

endmodule

// File: rtl/audio_adc_rx.sv
// audio_adc_rx: I2S ADC receiver. Captures left/right words on codec bit-clock
// rises (oversampled by clk), presents complete pairs on a valid/ready output
// with a sticky overrun flag. Optional peak meter: AUDIO_ADC_RX_PEAK_EN.
module audio_adc_rx
  import audio_pkg::*;
#(
  parameter int unsigned DATA_W       = AUDIO_DATA_W,
  parameter int unsigned PEAK_DECAY_W = 22
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              aud_bclk,
  input  logic              aud_adclrck,
  input  logic              aud_adcdat,
  output logic [DATA_W-1:0] ldata,
  output logic [DATA_W-1:0] rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overrun,
  input  logic              clr_overrun,
  output logic [3:0]        peak_l,
  output logic [3:0]        peak_r
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  logic [1:0]        pins_s;
  logic              bclk_rise;
  logic              lrck_s;
  logic              dat_s;

  rx_state_e         state, state_n, eff_state;
  logic [CNT_W-1:0]  bitcnt, bitcnt_n;
  logic [DATA_W-1:0] shreg, shreg_n;
  logic [DATA_W-1:0] l_reg, l_reg_n;
  logic [DATA_W-1:0] r_reg, r_reg_n;
  logic              left_flag, left_flag_n;
  logic              pair_stb, pair_stb_n;
  logic              lrck_q, lrck_vld, lrck_chg;

  sync_edge #(.W(2)) u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .edge_in (aud_bclk),
    .din     ({aud_adcdat, aud_adclrck}),
    .dout    (pins_s),
    .rise    (bclk_rise)
  );

  assign lrck_s = pins_s[0];
  assign dat_s  = pins_s[1];

  // Receiver state and capture registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= WAIT_SYNC;
      bitcnt    <= '0;
      shreg     <= '0;
      l_reg     <= '0;
      r_reg     <= '0;
      left_flag <= 1'b0;
      pair_stb  <= 1'b0;
      lrck_q    <= 1'b0;
      lrck_vld  <= 1'b0;
    end else begin
      state     <= state_n;
      bitcnt    <= bitcnt_n;
      shreg     <= shreg_n;
      l_reg     <= l_reg_n;
      r_reg     <= r_reg_n;
      left_flag <= left_flag_n;
      pair_stb  <= pair_stb_n;
      if (bclk_rise) begin
        lrck_q   <= lrck_s;
        lrck_vld <= 1'b1;
      end
    end
  end

  // Next-state and word assembly, evaluated on each bit-clock rise.
  always_comb begin
    state_n     = state;
    bitcnt_n    = bitcnt;
    shreg_n     = shreg;
    l_reg_n     = l_reg;
    r_reg_n     = r_reg;
    left_flag_n = left_flag;
    pair_stb_n  = 1'b0;
    eff_state   = state;
    lrck_chg    = 1'b0;
    if (bclk_rise) begin
      lrck_chg = lrck_vld && (lrck_s != lrck_q);
      // The rise that first shows a new lrck level is itself the I2S delay
      // slot, so it is consumed as SKIP in that same event.
      if (lrck_chg) eff_state = SKIP;
      case (eff_state)
        SKIP: begin
          state_n  = SHIFT;
          bitcnt_n = '0;
        end
        SHIFT: begin
          shreg_n  = {shreg[DATA_W-2:0], dat_s};
          bitcnt_n = bitcnt + CNT_W'(1);
          if (bitcnt == CNT_W'(DATA_W - 1)) begin
            state_n = HOLD;
            if (lrck_s == CH_LEFT) begin
              l_reg_n     = shreg_n;
              left_flag_n = 1'b1;
            end else if (lrck_s == CH_RIGHT && left_flag) begin
              r_reg_n     = shreg_n;
              left_flag_n = 1'b0;
              pair_stb_n  = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Output pair register with valid/ready handshake and sticky overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ldata     <= '0;
      rdata     <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (pair_stb) begin
        ldata     <= l_reg;
        rdata     <= r_reg;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      overrun <= (pair_stb && out_valid && !out_ready) || (overrun && !clr_overrun);
    end
  end

`ifdef AUDIO_ADC_RX_PEAK_EN
  logic [PEAK_DECAY_W-1:0] decay_cnt;
  logic [3:0]              lvl_l, lvl_r;
  logic [3:0]              peak_l_dec, peak_r_dec;
  logic [3:0]              peak_l_nxt, peak_r_nxt;

  function automatic logic [3:0] level_of(input logic [DATA_W-1:0] s);
    logic [DATA_W-1:0] mag;
    mag = s;
    if (s[DATA_W-1]) begin
      if (s[DATA_W-2:0] == '0) mag = {1'b0, {(DATA_W-1){1'b1}}};
      else                     mag = '0 - s;
    end
    return 4'(mag >> (DATA_W - 5));
  endfunction

  // Peak update: decay on counter wrap first, then take the max with the new pair.
  always_comb begin
    lvl_l      = level_of(l_reg);
    lvl_r      = level_of(r_reg);
    peak_l_dec = ((&decay_cnt) && peak_l != 4'd0) ? peak_l - 4'd1 : peak_l;
    peak_r_dec = ((&decay_cnt) && peak_r != 4'd0) ? peak_r - 4'd1 : peak_r;
    peak_l_nxt = peak_l_dec;
    peak_r_nxt = peak_r_dec;
    if (pair_stb) begin
      if (lvl_l > peak_l_dec) peak_l_nxt = lvl_l;
      if (lvl_r > peak_r_dec) peak_r_nxt = lvl_r;
    end
  end

  // Free-running decay timer and peak registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      decay_cnt <= '0;
      peak_l    <= '0;
      peak_r    <= '0;
    end else begin
      decay_cnt <= decay_cnt + 1'b1;
      peak_l    <= peak_l_nxt;
      peak_r    <= peak_r_nxt;
    end
  end
`else
  assign peak_l = '0;
  assign peak_r = '0;
`endif

endmodule

// File: tb/tb_audio_adc_rx.sv
// Directed bench for audio_adc_rx: I2S frames with 32-bit slots (delay slot,
// 16 data bits, 15 padding bits), bclk = clk/8.
module tb_audio_adc_rx;

  localparam int unsigned DW  = 16;
  localparam int unsigned PDW = 12;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          aud_bclk, aud_adclrck, aud_adcdat;
  logic [DW-1:0] ldata, rdata;
  logic          out_valid, out_ready, overrun, clr_overrun;
  logic [3:0]    peak_l, peak_r;

  int            checks = 0;
  int            passes = 0;
  int            xfers  = 0;
  logic [DW-1:0] last_l, last_r;

  always #5 clk = ~clk;

  audio_adc_rx #(.DATA_W(DW), .PEAK_DECAY_W(PDW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .aud_bclk    (aud_bclk),
    .aud_adclrck (aud_adclrck),
    .aud_adcdat  (aud_adcdat),
    .ldata       (ldata),
    .rdata       (rdata),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .overrun     (overrun),
    .clr_overrun (clr_overrun),
    .peak_l      (peak_l),
    .peak_r      (peak_r)
  );

  // Record every accepted pair.
  always @(posedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      xfers  = xfers + 1;
      last_l = ldata;
      last_r = rdata;
    end
  end

  task automatic send_bit(input logic l, input logic d);
    aud_adclrck = l;
    aud_adcdat  = d;
    repeat (4) @(posedge clk);
    #1 aud_bclk = 1'b1;
    repeat (4) @(posedge clk);
    #1 aud_bclk = 1'b0;
  endtask

  task automatic send_slot(input logic ch, input logic [15:0] w,
                           input int unsigned ndata, input int unsigned npad);
    send_bit(ch, 1'b1);
    for (int unsigned i = 0; i < ndata; i++) send_bit(ch, w[15-i]);
    for (int unsigned i = 0; i < npad; i++) send_bit(ch, 1'b0);
  endtask

  task automatic send_frame(input logic [15:0] l, input logic [15:0] r);
    send_slot(1'b0, l, 16, 15);
    send_slot(1'b1, r, 16, 15);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (ldata !== 16'h0) $display("FAIL reset_ldata: got %h want 0000", ldata); else passes++;
    checks++; if (rdata !== 16'h0) $display("FAIL reset_rdata: got %h want 0000", rdata); else passes++;
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else passes++;
    checks++; if (overrun !== 1'b0) $display("FAIL reset_overrun: got %b want 0", overrun); else passes++;
    checks++; if (peak_l !== 4'd0) $display("FAIL reset_peak_l: got %0d want 0", peak_l); else passes++;
    checks++; if (peak_r !== 4'd0) $display("FAIL reset_peak_r: got %0d want 0", peak_r); else passes++;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_peak;
    logic [3:0] exp15, exp14;
`ifdef AUDIO_ADC_RX_PEAK_EN
    exp15 = 4'd15;
    exp14 = 4'd14;
`else
    exp15 = 4'd0;
    exp14 = 4'd0;
`endif
    out_ready = 1'b0;
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_slot(1'b0, 16'h8000, 16, 15);
    send_slot(1'b1, 16'h0000, 16, 0);
    checks++; if (out_valid !== 1'b1) $display("FAIL peak_valid: got %b want 1", out_valid); else passes++;
    checks++; if (ldata !== 16'h8000) $display("FAIL peak_ldata: got %h want 8000", ldata); else passes++;
    checks++; if (peak_l !== exp15) $display("FAIL peak_l_max: got %0d want %0d", peak_l, exp15); else passes++;
    checks++; if (peak_r !== 4'd0) $display("FAIL peak_r_zero: got %0d want 0", peak_r); else passes++;
    repeat (1 << PDW) @(posedge clk);
    #1;
    checks++; if (peak_l !== exp14) $display("FAIL peak_l_decay: got %0d want %0d", peak_l, exp14); else passes++;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) $display("FAIL peak_xfer: got %b want 0", out_valid); else passes++;
  endtask

  task automatic test_single;
    int x0;
    x0 = xfers;
    out_ready = 1'b1;
    send_frame(16'h1234, 16'hABCD);
    checks++; if (xfers !== x0 + 1) $display("FAIL single_count: got %0d want %0d", xfers - x0, 1); else passes++;
    checks++; if (last_l !== 16'h1234) $display("FAIL single_ldata: got %h want 1234", last_l); else passes++;
    checks++; if (last_r !== 16'hABCD) $display("FAIL single_rdata: got %h want abcd", last_r); else passes++;
    checks++; if (overrun !== 1'b0) $display("FAIL single_overrun: got %b want 0", overrun); else passes++;
    checks++; if (out_valid !== 1'b0) $display("FAIL single_valid_low: got %b want 0", out_valid); else passes++;
  endtask

  task automatic test_latency;
    logic [15:0] w;
    w = 16'hF0F0;
    out_ready = 1'b0;
    send_slot(1'b0, 16'h0F0F, 16, 15);
    send_bit(1'b1, 1'b1);
    for (int unsigned i = 0; i < 15; i++) send_bit(1'b1, w[15-i]);
    aud_adcdat = w[0];
    repeat (4) @(posedge clk);
    #1 aud_bclk = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) $display("FAIL latency_early: got %b want 0 at 3 clk", out_valid); else passes++;
    @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b1) $display("FAIL latency_4clk: got %b want 1 at 4 clk", out_valid); else passes++;
    aud_bclk = 1'b0;
    for (int unsigned i = 0; i < 15; i++) send_bit(1'b1, 1'b0);
    checks++; if (ldata !== 16'h0F0F) $display("FAIL latency_ldata: got %h want 0f0f", ldata); else passes++;
    checks++; if (rdata !== 16'hF0F0) $display("FAIL latency_rdata: got %h want f0f0", rdata); else passes++;
    checks++; if (out_valid !== 1'b1) $display("FAIL latency_hold: got %b want 1", out_valid); else passes++;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) $display("FAIL latency_xfer: got %b want 0", out_valid); else passes++;
  endtask

  task automatic test_overrun;
    out_ready   = 1'b0;
    clr_overrun = 1'b0;
    send_frame(16'h1111, 16'h2222);
    checks++; if (out_valid !== 1'b1) $display("FAIL ovr_first_valid: got %b want 1", out_valid); else passes++;
    checks++; if (overrun !== 1'b0) $display("FAIL ovr_first_flag: got %b want 0", overrun); else passes++;
    send_frame(16'h3333, 16'h4444);
    send_frame(16'h5555, 16'h6666);
    checks++; if (out_valid !== 1'b1) $display("FAIL ovr_valid: got %b want 1", out_valid); else passes++;
    checks++; if (ldata !== 16'h5555) $display("FAIL ovr_ldata: got %h want 5555", ldata); else passes++;
    checks++; if (rdata !== 16'h6666) $display("FAIL ovr_rdata: got %h want 6666", rdata); else passes++;
    checks++; if (overrun !== 1'b1) $display("FAIL ovr_flag: got %b want 1", overrun); else passes++;
    clr_overrun = 1'b1;
    @(posedge clk);
    #1 clr_overrun = 1'b0;
    checks++; if (overrun !== 1'b0) $display("FAIL ovr_clear: got %b want 0", overrun); else passes++;
    checks++; if (out_valid !== 1'b1) $display("FAIL ovr_clear_valid: got %b want 1", out_valid); else passes++;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) $display("FAIL ovr_xfer: got %b want 0", out_valid); else passes++;
  endtask

  task automatic test_partial;
    int x0;
    x0 = xfers;
    out_ready = 1'b1;
    send_slot(1'b0, 16'hDEAD, 9, 0);
    send_slot(1'b1, 16'hBEEF, 16, 15);
    checks++; if (xfers !== x0) $display("FAIL partial_none: got %0d pairs want 0", xfers - x0); else passes++;
    checks++; if (out_valid !== 1'b0) $display("FAIL partial_valid: got %b want 0", out_valid); else passes++;
    send_frame(16'hCAFE, 16'hF00D);
    checks++; if (xfers !== x0 + 1) $display("FAIL partial_next_count: got %0d want 1", xfers - x0); else passes++;
    checks++; if (last_l !== 16'hCAFE) $display("FAIL partial_next_l: got %h want cafe", last_l); else passes++;
    checks++; if (last_r !== 16'hF00D) $display("FAIL partial_next_r: got %h want f00d", last_r); else passes++;
  endtask

  task automatic test_mid_right;
    int x0;
    logic [15:0] w;
    w = 16'h5A5A;
    rst_n = 1'b0;
    aud_adclrck = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    x0 = xfers;
    for (int unsigned i = 9; i < 16; i++) send_bit(1'b1, w[15-i]);
    for (int unsigned i = 0; i < 15; i++) send_bit(1'b1, 1'b0);
    send_frame(16'h0246, 16'h8ACE);
    checks++; if (xfers !== x0 + 1) $display("FAIL midr_count: got %0d want 1", xfers - x0); else passes++;
    checks++; if (last_l !== 16'h0246) $display("FAIL midr_l: got %h want 0246", last_l); else passes++;
    checks++; if (last_r !== 16'h8ACE) $display("FAIL midr_r: got %h want 8ace", last_r); else passes++;
  endtask

  task automatic test_reset_mid;
    int x0;
    logic [15:0] w;
    w = 16'h7777;
    out_ready = 1'b1;
    x0 = xfers;
    send_bit(1'b0, 1'b1);
    for (int unsigned i = 0; i < 7; i++) send_bit(1'b0, w[15-i]);
    aud_adcdat = w[8];
    repeat (4) @(posedge clk);
    #1 aud_bclk = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (ldata !== 16'h0) $display("FAIL rstmid_ldata: got %h want 0000", ldata); else passes++;
    checks++; if (rdata !== 16'h0) $display("FAIL rstmid_rdata: got %h want 0000", rdata); else passes++;
    checks++; if (out_valid !== 1'b0) $display("FAIL rstmid_valid: got %b want 0", out_valid); else passes++;
    checks++; if (overrun !== 1'b0) $display("FAIL rstmid_overrun: got %b want 0", overrun); else passes++;
    checks++; if (peak_l !== 4'd0) $display("FAIL rstmid_peak_l: got %0d want 0", peak_l); else passes++;
    rst_n = 1'b1;
    @(posedge clk);
    #1 aud_bclk = 1'b0;
    for (int unsigned i = 8; i < 16; i++) send_bit(1'b0, w[15-i]);
    for (int unsigned i = 0; i < 15; i++) send_bit(1'b0, 1'b0);
    send_slot(1'b1, 16'h9999, 16, 15);
    checks++; if (xfers !== x0) $display("FAIL rstmid_none: got %0d pairs want 0", xfers - x0); else passes++;
    checks++; if (out_valid !== 1'b0) $display("FAIL rstmid_no_valid: got %b want 0", out_valid); else passes++;
    send_frame(16'h1357, 16'h2468);
    checks++; if (xfers !== x0 + 1) $display("FAIL rstmid_next_count: got %0d want 1", xfers - x0); else passes++;
    checks++; if (last_l !== 16'h1357) $display("FAIL rstmid_next_l: got %h want 1357", last_l); else passes++;
    checks++; if (last_r !== 16'h2468) $display("FAIL rstmid_next_r: got %h want 2468", last_r); else passes++;
  endtask

  initial begin
    rst_n       = 1'b0;
    aud_bclk    = 1'b0;
    aud_adclrck = 1'b1;
    aud_adcdat  = 1'b0;
    out_ready   = 1'b0;
    clr_overrun = 1'b0;
    test_reset;
    test_peak;
    test_single;
    test_latency;
    test_overrun;
    test_partial;
    test_mid_right;
    test_reset_mid;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
